// File: rtl/regfile_mp_if.sv
// Register-file port bundle: write lanes, read ports and busy-scoreboard controls.
// master drives requests (decode/writeback side), slave is the register file.
interface regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int AW     = $clog2(NREGS)
);
    logic [NUM_WR-1:0]      we;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   sb_set;
    logic [AW-1:0]          sb_addr;
    logic                   flush;

    modport master (
        output we, wr_addr, wr_data, rd_addr, sb_set, sb_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  we, wr_addr, wr_data, rd_addr, sb_set, sb_addr, flush,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard and write->read bypass.
// Latency: reads are combinational (0 cycles); writes and busy updates land at the next posedge.
// Backpressure: none; every port is accepted each cycle, consumers stall on rd_busy.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input logic         clk_i,
    input logic         rst_i,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic [NUM_RD*XLEN-1:0] rd_data_d;
    logic [NUM_RD-1:0]      rd_busy_d;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(NREGS);
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Lanes are walked low to high so the highest lane's write and data win.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.we[k] && addr_ok(bus.wr_addr[k*AW +: AW])) begin
                busy_d[bus.wr_addr[k*AW +: AW]] = 1'b0;
                if (!is_zero(bus.wr_addr[k*AW +: AW])) begin
                    mem_d[bus.wr_addr[k*AW +: AW]] = bus.wr_data[k*XLEN +: XLEN];
                end
            end
        end
        if (bus.flush) begin
            busy_d = '0;
        end
        // A new producer issued alongside a clear or flush keeps its register pending.
        if (bus.sb_set && addr_ok(bus.sb_addr) && !is_zero(bus.sb_addr)) begin
            busy_d[bus.sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (addr_ok(bus.rd_addr[r*AW +: AW]) && !is_zero(bus.rd_addr[r*AW +: AW])) begin
                rd_data_d[r*XLEN +: XLEN] = mem_q[bus.rd_addr[r*AW +: AW]];
                rd_busy_d[r]              = busy_q[bus.rd_addr[r*AW +: AW]];
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.we[k] && (bus.wr_addr[k*AW +: AW] == bus.rd_addr[r*AW +: AW])) begin
                        rd_data_d[r*XLEN +: XLEN] = bus.wr_data[k*XLEN +: XLEN];
                        rd_busy_d[r]              = 1'b0;
                    end
                end
            end
        end
    end

    assign bus.rd_data = rd_data_d;
    assign bus.rd_busy = rd_busy_d;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed stimulus pushes expected read results, a negedge monitor checks them.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_vld = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [31:0] d0;
        logic        b0;
        logic [31:0] d1;
        logic        b1;
    } exp_t;

    exp_t exp_q[$];

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: whenever the stimulus flags a read as valid, pop and compare both ports.
    always @(negedge clk) begin
        if (chk_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got read with no expectation, required queued entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.rd_data[31:0] !== e.d0) begin
                    errors++;
                    $display("FAIL %s p0_data: got %h required %h", e.name, bus.rd_data[31:0], e.d0);
                end
                checks++;
                if (bus.rd_busy[0] !== e.b0) begin
                    errors++;
                    $display("FAIL %s p0_busy: got %b required %b", e.name, bus.rd_busy[0], e.b0);
                end
                checks++;
                if (bus.rd_data[63:32] !== e.d1) begin
                    errors++;
                    $display("FAIL %s p1_data: got %h required %h", e.name, bus.rd_data[63:32], e.d1);
                end
                checks++;
                if (bus.rd_busy[1] !== e.b1) begin
                    errors++;
                    $display("FAIL %s p1_busy: got %b required %b", e.name, bus.rd_busy[1], e.b1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.we      = '0;
        bus.sb_set  = 1'b0;
        bus.flush   = 1'b0;
        chk_vld     = 1'b0;
    endtask

    task automatic wr(input int lane, input logic [4:0] a, input logic [31:0] d);
        bus.we[lane]                = 1'b1;
        bus.wr_addr[lane*AW +: AW]  = a;
        bus.wr_data[lane*32 +: 32]  = d;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic setb(input logic [4:0] a);
        bus.sb_set  = 1'b1;
        bus.sb_addr = a;
    endtask

    task automatic step(input string name, input logic [31:0] d0, input logic b0,
                        input logic [31:0] d1, input logic b1);
        exp_t e;
        e.name = name; e.d0 = d0; e.b0 = b0; e.d1 = d1; e.b1 = b1;
        exp_q.push_back(e);
        chk_vld = 1'b1;
        tick();
    endtask

    initial begin
        bus.we = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        bus.sb_set = 1'b0; bus.sb_addr = '0; bus.flush = 1'b0;

        // Reset cycle with writes and a set pending: all must be discarded.
        rst = 1'b1;
        wr(0, 5'd5, 32'h1234_5678);
        wr(1, 5'd6, 32'h8765_4321);
        setb(5'd6);
        tick();
        for (int a = 0; a < 16; a++) begin
            rd(5'(a), 5'(a + 16));
            step("reset", 32'h0, 1'b0, 32'h0, 1'b0);
        end

        // Bypass then storage read.
        wr(0, 5'd5, 32'hDEAD_BEEF); rd(5'd5, 5'd6);
        step("bypass_r5", 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        rd(5'd5, 5'd6);
        step("stored_r5", 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);

        // Two lanes to one register: highest lane wins.
        wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(5'd7, 5'd5);
        step("lane_prio_byp", 32'h22, 1'b0, 32'hDEAD_BEEF, 1'b0);
        rd(5'd7, 5'd7);
        step("lane_prio_st", 32'h22, 1'b0, 32'h22, 1'b0);

        // Register 0 is hardwired.
        wr(0, 5'd0, 32'hFFFF_FFFF); setb(5'd0); rd(5'd0, 5'd7);
        step("r0_same", 32'h0, 1'b0, 32'h22, 1'b0);
        rd(5'd0, 5'd0);
        step("r0_next", 32'h0, 1'b0, 32'h0, 1'b0);

        // Busy set, clear by write, set+write together.
        setb(5'd3); rd(5'd3, 5'd7);
        step("set_same", 32'h0, 1'b0, 32'h22, 1'b0);
        rd(5'd3, 5'd3);
        step("set_next", 32'h0, 1'b1, 32'h0, 1'b1);
        wr(0, 5'd3, 32'h5); rd(5'd3, 5'd7);
        step("clr_byp", 32'h5, 1'b0, 32'h22, 1'b0);
        rd(5'd3, 5'd3);
        step("clr_next", 32'h5, 1'b0, 32'h5, 1'b0);
        setb(5'd3); wr(0, 5'd3, 32'h9); rd(5'd3, 5'd3);
        step("setwr_same", 32'h9, 1'b0, 32'h9, 1'b0);
        rd(5'd3, 5'd7);
        step("setwr_next", 32'h9, 1'b1, 32'h22, 1'b0);
        wr(1, 5'd3, 32'hA); rd(5'd3, 5'd3);
        step("lane1_clr_byp", 32'hA, 1'b0, 32'hA, 1'b0);
        rd(5'd3, 5'd3);
        step("lane1_clr_next", 32'hA, 1'b0, 32'hA, 1'b0);

        // Flush with concurrent set.
        wr(0, 5'd1, 32'h77); wr(1, 5'd2, 32'h88);
        tick();
        setb(5'd1); rd(5'd1, 5'd2);
        step("busy_r1_same", 32'h77, 1'b0, 32'h88, 1'b0);
        setb(5'd2); rd(5'd1, 5'd2);
        step("busy_r1", 32'h77, 1'b1, 32'h88, 1'b0);
        bus.flush = 1'b1; setb(5'd4); rd(5'd1, 5'd2);
        step("flush_same", 32'h77, 1'b1, 32'h88, 1'b1);
        rd(5'd1, 5'd2);
        step("flush_r1r2", 32'h77, 1'b0, 32'h88, 1'b0);
        rd(5'd4, 5'd2);
        step("flush_r4", 32'h0, 1'b1, 32'h88, 1'b0);

        // Repeated set stays busy; a single write clears it.
        setb(5'd4); rd(5'd4, 5'd4);
        step("reset_busy", 32'h0, 1'b1, 32'h0, 1'b1);
        wr(1, 5'd4, 32'hC0DE_0004);
        tick();
        rd(5'd4, 5'd1);
        step("one_clear", 32'hC0DE_0004, 1'b0, 32'h77, 1'b0);

        // Reset mid-operation discards a concurrent write and set.
        setb(5'd9);
        tick();
        rst = 1'b1; wr(0, 5'd9, 32'h99); setb(5'd4);
        tick();
        rd(5'd9, 5'd5);
        step("rst_mid_a", 32'h0, 1'b0, 32'h0, 1'b0);
        rd(5'd4, 5'd7);
        step("rst_mid_b", 32'h0, 1'b0, 32'h0, 1'b0);

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
